// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA test-pattern path.
// Holds the pattern/state enums, active-area defaults, bar splits and rgb_t.
package vga_pkg;
  typedef enum logic [1:0] {
    SOLID, BARS, CHECKER, RAMP
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE, AUTO, MANUAL
  } seq_state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int BAR_SPLIT_1  = 214;
  localparam int BAR_SPLIT_2  = 427;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t BLACK = '{8'h00, 8'h00, 8'h00};
  localparam rgb_t WHITE = '{8'hff, 8'hff, 8'hff};
  localparam rgb_t RED   = '{8'hff, 8'h00, 8'h00};
  localparam rgb_t GREEN = '{8'h00, 8'hff, 8'h00};
  localparam rgb_t BLUE  = '{8'h00, 8'h00, 8'hff};
endpackage

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: combinational (pattern, Column, Row, inDisplayArea) -> rgb.
// With VGA_SEQ_BORDER_EN, border_en forces the active-area edge to white.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int CHECK_SHIFT = 5
) (
  input  pattern_e   pattern,
  input  logic [9:0] Column,
  input  logic [9:0] Row,
  input  logic       inDisplayArea,
`ifdef VGA_SEQ_BORDER_EN
  input  logic       border_en,
`endif
  output rgb_t       rgb
);
  logic border_px;
  logic sq;

  assign border_px = (Column == '0)
                  || (Column == 10'(H_ACTIVE - 1))
                  || (Row == '0)
                  || (Row == 10'(V_ACTIVE - 1));

  assign sq = Column[CHECK_SHIFT] ^ Row[CHECK_SHIFT];

  always_comb begin
    rgb = BLACK;
    if (inDisplayArea) begin
      case (pattern)
        SOLID: rgb = RED;
        BARS: begin
          if (Column < 10'(BAR_SPLIT_1))
            rgb = GREEN ^ GREEN ^ RED;
          else if (Column < 10'(BAR_SPLIT_2))
            rgb = GREEN;
          else
            rgb = BLUE;
        end
        CHECKER: rgb = sq ? WHITE : BLACK;
        RAMP: rgb = '{Column[9:2], Column[9:2], Column[9:2]};
        default: rgb = BLACK;
      endcase
`ifdef VGA_SEQ_BORDER_EN
      if (border_en && border_px)
        rgb = WHITE;
`endif
    end
  end

`ifndef VGA_SEQ_BORDER_EN
  logic unused_border;
  assign unused_border = border_px;
`endif
endmodule

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: cycles four test patterns (AUTO) or holds one (MANUAL),
// switching only at vsync falls; registers RGB/syncs. Option: VGA_SEQ_BORDER_EN.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE           = H_ACTIVE_DEF,
  parameter int V_ACTIVE           = V_ACTIVE_DEF,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int CHECK_SHIFT        = 5
) (
  input  logic       pxclk,
  input  logic       rst_n,
  input  logic [9:0] Column,
  input  logic [9:0] Row,
  input  logic       inDisplayArea,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_auto,
  input  logic [1:0] cmd_pattern,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] pattern_idx,
  output logic       frame_tick
);
  localparam int CW =
    (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_PATTERN - 1);

  seq_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  pattern_e      pat, pat_n;
  logic          pend_v, pend_v_n;
  logic          pend_auto, pend_auto_n;
  pattern_e      pend_pat, pend_pat_n;
  logic          boundary;
  logic          accept;
  rgb_t          pix;
  rgb_t          pix_d;

  // vsync_out doubles as the registered copy for edge detection.
  assign boundary    = vsync_out & ~vsync_in;
  assign cmd_ready   = ~pend_v;
  assign accept      = cmd_valid & cmd_ready;
  assign pattern_idx = pat;

  vga_pattern_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .CHECK_SHIFT (CHECK_SHIFT)
  ) u_gen (
    .pattern       (pat),
    .Column        (Column),
    .Row           (Row),
    .inDisplayArea (inDisplayArea),
`ifdef VGA_SEQ_BORDER_EN
    .border_en     (state != IDLE),
`endif
    .rgb           (pix)
  );

  assign pix_d = (state == IDLE) ? BLACK : pix;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pat_n       = pat;
    pend_v_n    = pend_v;
    pend_auto_n = pend_auto;
    pend_pat_n  = pend_pat;
    if (boundary) begin
      if (pend_v) begin
        state_n  = pend_auto ? AUTO : MANUAL;
        cnt_n    = '0;
        pat_n    = pend_pat;
        pend_v_n = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state_n = AUTO;
            cnt_n   = '0;
          end
          AUTO: begin
            if (cnt == LAST) begin
              cnt_n = '0;
              pat_n = pattern_e'(pat + 2'd1);
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
          default: cnt_n = '0;
        endcase
      end
    end
    // Accept is only possible with nothing pending, so a command taken
    // on a boundary cycle waits for the following boundary.
    if (accept) begin
      pend_v_n    = 1'b1;
      pend_auto_n = cmd_auto;
      pend_pat_n  = pattern_e'(cmd_pattern);
    end
  end

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pat        <= SOLID;
      pend_v     <= 1'b0;
      pend_auto  <= 1'b0;
      pend_pat   <= SOLID;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pat        <= pat_n;
      pend_v     <= pend_v_n;
      pend_auto  <= pend_auto_n;
      pend_pat   <= pend_pat_n;
      red        <= pix_d.r;
      green      <= pix_d.g;
      blue       <= pix_d.b;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      frame_tick <= boundary;
    end
  end
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer: directed bench for the pattern sequencer.
// Table of pixel vectors plus hand sequences for frame/command corners.
module tb_vga_pattern_sequencer;
  logic       pxclk = 1'b0;
  logic       rst_n;
  logic [9:0] Column;
  logic [9:0] Row;
  logic       inDisplayArea;
  logic       hsync_in;
  logic       vsync_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_auto;
  logic [1:0] cmd_pattern;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       hsync_out;
  logic       vsync_out;
  logic [1:0] pattern_idx;
  logic       frame_tick;

  int n_pass = 0;
  int n_total = 0;

`ifdef VGA_SEQ_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  localparam int C_RED   = 24'hff0000;
  localparam int C_GREEN = 24'h00ff00;
  localparam int C_BLUE  = 24'h0000ff;
  localparam int C_WHITE = 24'hffffff;
  localparam int C_BLACK = 24'h000000;

  typedef struct {
    int pat;
    int col;
    int row;
    bit de;
    int r;
    int g;
    int b;
  } vec_t;

  vec_t tv[11];
  int   exp_idx[9];
  int   cur;

  vga_pattern_sequencer #(
    .H_ACTIVE           (640),
    .V_ACTIVE           (480),
    .FRAMES_PER_PATTERN (2),
    .CHECK_SHIFT        (5)
  ) dut (
    .pxclk         (pxclk),
    .rst_n         (rst_n),
    .Column        (Column),
    .Row           (Row),
    .inDisplayArea (inDisplayArea),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_auto      (cmd_auto),
    .cmd_pattern   (cmd_pattern),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .pattern_idx   (pattern_idx),
    .frame_tick    (frame_tick)
  );

  always #5 pxclk = ~pxclk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_rgb(input string nm, input int exp);
    chk(nm, int'({red, green, blue}), exp);
  endtask

  task automatic step();
    @(posedge pxclk);
    #1;
  endtask

  task automatic set_cmd(input bit au, input int p);
    cmd_valid   = 1'b1;
    cmd_auto    = au;
    cmd_pattern = 2'(p);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic set_manual(input int p);
    set_cmd(1'b0, p);
    step();
    vsync_in = 1'b0;
    step();
    chk("manual_switch", int'(pattern_idx), p);
    vsync_in = 1'b1;
    step();
  endtask

  initial begin
    tv[0]  = '{1, 426,  10, 1'b1,   0, 255,   0};
    tv[1]  = '{1, 427,  10, 1'b1,   0,   0, 255};
    tv[2]  = '{1, 300, 300, 1'b0,   0,   0,   0};
    tv[3]  = '{3, 100,  10, 1'b1,  25,  25,  25};
    tv[4]  = '{3, 636, 200, 1'b1, 159, 159, 159};
    tv[5]  = '{3, 400,  10, 1'b0,   0,   0,   0};
    tv[6]  = '{2,  31,  32, 1'b1, 255, 255, 255};
    tv[7]  = '{2,  32,  32, 1'b1,   0,   0,   0};
    tv[8]  = '{2,  64,  10, 1'b1,   0,   0,   0};
    tv[9]  = '{0, 320, 240, 1'b1, 255,   0,   0};
    tv[10] = '{0, 320, 240, 1'b0,   0,   0,   0};
    exp_idx = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    rst_n = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b1;
    inDisplayArea = 1'b1;
    Column = 10'd100;
    Row = 10'd10;
    cmd_valid = 1'b0;
    cmd_auto = 1'b0;
    cmd_pattern = 2'd0;

    repeat (3) step();
    chk_rgb("rst_rgb", C_BLACK);
    chk("rst_hsync", int'(hsync_out), 1);
    chk("rst_vsync", int'(vsync_out), 1);
    chk("rst_idx", int'(pattern_idx), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_tick", int'(frame_tick), 0);

    rst_n = 1'b1;
    step();
    chk("hsync_delay", int'(hsync_out), 0);
    chk_rgb("idle_black", C_BLACK);
    hsync_in = 1'b1;
    step();
    chk("hsync_delay_hi", int'(hsync_out), 1);

    for (int i = 0; i < 9; i++) begin
      vsync_in = 1'b0;
      step();
      chk($sformatf("auto_idx_%0d", i), int'(pattern_idx), exp_idx[i]);
      chk($sformatf("tick_on_%0d", i), int'(frame_tick), 1);
      if (i == 0) chk("vsync_delay", int'(vsync_out), 0);
      vsync_in = 1'b1;
      step();
      chk($sformatf("tick_off_%0d", i), int'(frame_tick), 0);
      if (i == 0) chk_rgb("auto_first_red", C_RED);
      repeat (2) step();
    end

    Column = 10'd32;
    Row = 10'd0;
    set_cmd(1'b0, 2);
    chk("man_ready_lo", int'(cmd_ready), 0);
    chk("man_old_pix", int'(pattern_idx), 0);
    step();
    chk_rgb("man_pre_pix", BORDER ? C_WHITE : C_RED);
    chk("man_ready_lo2", int'(cmd_ready), 0);
    vsync_in = 1'b0;
    #1;
    chk("man_ready_bnd", int'(cmd_ready), 0);
    step();
    chk("man_idx", int'(pattern_idx), 2);
    chk("man_ready_hi", int'(cmd_ready), 1);
    vsync_in = 1'b1;
    step();
    chk_rgb("chk_32_0", C_WHITE);
    Column = 10'd0;
    step();
    chk_rgb("chk_0_0", BORDER ? C_WHITE : C_BLACK);
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    chk("man_hold", int'(pattern_idx), 2);
    step();

    cmd_valid = 1'b1;
    cmd_auto = 1'b0;
    cmd_pattern = 2'd1;
    vsync_in = 1'b0;
    step();
    cmd_valid = 1'b0;
    vsync_in = 1'b1;
    chk("bndcmd_not_now", int'(pattern_idx), 2);
    chk("bndcmd_ready", int'(cmd_ready), 0);
    chk("bndcmd_tick", int'(frame_tick), 1);
    repeat (2) step();
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    chk("bndcmd_applied", int'(pattern_idx), 1);
    chk("bndcmd_ready_hi", int'(cmd_ready), 1);
    step();

    Column = 10'd213;
    Row = 10'd10;
    step();
    chk_rgb("bar_213", C_RED);
    Column = 10'd214;
    #1;
    chk_rgb("bar_latency", C_RED);
    step();
    chk_rgb("bar_214", C_GREEN);
    Column = 10'd0;
    step();
    chk_rgb("bar_0_10", BORDER ? C_WHITE : C_RED);

    cur = 1;
    for (int i = 0; i < 11; i++) begin
      if (tv[i].pat != cur) begin
        set_manual(tv[i].pat);
        cur = tv[i].pat;
      end
      Column = 10'(tv[i].col);
      Row = 10'(tv[i].row);
      inDisplayArea = tv[i].de;
      step();
      chk($sformatf("vec_%0d", i), int'({red, green, blue}),
          (tv[i].r << 16) | (tv[i].g << 8) | tv[i].b);
    end

    Column = 10'd100;
    Row = 10'd10;
    inDisplayArea = 1'b1;
    set_cmd(1'b1, 3);
    step();
    for (int i = 0; i < 3; i++) begin
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      chk($sformatf("autocmd_%0d", i), int'(pattern_idx), (i < 2) ? 3 : 0);
      repeat (2) step();
    end

    set_cmd(1'b0, 2);
    chk("pend_before_rst", int'(cmd_ready), 0);
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst2_ready", int'(cmd_ready), 1);
    chk("rst2_idx", int'(pattern_idx), 0);
    chk_rgb("rst2_black", C_BLACK);
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    chk("rst2_idx_bnd", int'(pattern_idx), 0);
    chk("rst2_tick", int'(frame_tick), 1);
    step();
    chk_rgb("rst2_auto_red", C_RED);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vga_pattern_sequencer.md
# vga_pattern_sequencer

Test-pattern controller for the VGA pipeline. It sits between the VGA timing controller (`Column`, `Row`, `inDisplayArea`, syncs) and the DAC pins. It sequences four built-in patterns, either advancing automatically every N frames or holding a host-selected pattern. Pattern changes take effect only at frame boundaries. RGB and sync outputs are registered and kept aligned.

## Interface
Parameters:
- `H_ACTIVE`, default 640: active columns.
- `V_ACTIVE`, default 480: active rows.
- `FRAMES_PER_PATTERN`, default 60: frames each pattern is held in AUTO mode; must be ≥1.
- `CHECK_SHIFT`, default 5: checkerboard square size is 2^CHECK_SHIFT pixels.

Ports:
- `pxclk`, in, 1: pixel clock. The block's only clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `Column`, in, 10: current column from the timing controller.
- `Row`, in, 10: current row from the timing controller.
- `inDisplayArea`, in, 1: high while in the active area.
- `hsync_in`, in, 1: horizontal sync, active-low.
- `vsync_in`, in, 1: vertical sync, active-low.
- `cmd_valid`, in, 1: host command valid.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_auto`, in, 1: 1 selects AUTO mode; 0 selects MANUAL mode.
- `cmd_pattern`, in, 2: pattern index to show, used in MANUAL mode.
- `red`, `green`, `blue`, out, 8 each: pixel colour, registered.
- `hsync_out`, `vsync_out`, out, 1 each: sync signals delayed by 1 cycle.
- `pattern_idx`, out, 2: pattern currently displayed.
- `frame_tick`, out, 1: one-cycle pulse at each frame boundary.

## Operation
- Frame boundary: the first cycle `vsync_in` is sampled 0 after having been sampled 1 (falling edge against a registered copy).
- States:
  - IDLE (reset state): output is black; `pattern_idx`=0. Moves to AUTO at the first frame boundary.
  - AUTO: at each boundary, frame counter increments. When it reaches FRAMES_PER_PATTERN−1, the counter goes to 0 and `pattern_idx` advances by 1, wrapping 3→0.
  - MANUAL: `pattern_idx` is held. The frame counter is held at 0.
- Commands:
  - A command is accepted when `cmd_valid && cmd_ready`. It is latched into a pending register and `cmd_ready` drops to 0.
  - At the next frame boundary the pending command is applied and `cmd_ready` returns to 1.
  - cmd_auto=1: go to AUTO, counter=0, `pattern_idx`=`cmd_pattern`.
  - cmd_auto=0: go to MANUAL, `pattern_idx`=`cmd_pattern`.
  - A pending command applied at a boundary overrides the AUTO advance for that boundary.
  - A command accepted in the same cycle as a boundary is applied at the following boundary, not the current one.
  - A command accepted while in IDLE is applied at the first boundary instead of the default IDLE→AUTO transition.
- Patterns (applied when `inDisplayArea`=1; otherwise RGB=0):
  - 0, solid red: (255,0,0).
  - 1, bars: `Column`<214 gives red; <427 gives green; otherwise blue (each full 255).
  - 2, checkerboard: `Column[CHECK_SHIFT]^Row[CHECK_SHIFT]` = 1 gives white (255,255,255), else black.
  - 3, grey ramp: r=g=b=`Column[9:2]`.
- Arithmetic: frame counter width is $clog2(FRAMES_PER_PATTERN) with a minimum of 1. It compares for equality only, with no overflow path.

## Timing
- Pixel latency is 1 cycle: inputs sampled at edge N appear on RGB and syncs after edge N.
- `hsync_out`/`vsync_out` are `hsync_in`/`vsync_in` delayed by 1 cycle, matching RGB.
- `frame_tick`, `pattern_idx` and state all update on the same edge, the one at which the boundary is detected.
- Reset values: RGB=0, `hsync_out`=1, `vsync_out`=1, `pattern_idx`=0, `frame_tick`=0, `cmd_ready`=1, state IDLE, counter=0, pending cleared.
- Reset mid-frame: all values above are restored at the next edge and any pending command is discarded.
- `cmd_ready` is low from the cycle after acceptance through the boundary cycle, and high again in the cycle after.

## Configuration
- `VGA_SEQ_BORDER_EN`:
  - Defined: pixels with `Column`∈{0, H_ACTIVE−1} or `Row`∈{0, V_ACTIVE−1} are forced to white (255,255,255), overriding the pattern, in every state except IDLE.
  - Undefined: no border logic; patterns are shown unmodified.

## Structure
- Shared package `vga_pkg` holds:
  - `pattern_e` enum: SOLID, BARS, CHECKER, RAMP.
  - `seq_state_e` enum: IDLE, AUTO, MANUAL.
  - Default H/V active constants.
  - Bar split constants 214 and 427.
- Sub-module `vga_pattern_gen`: combinational mapping of (pattern, `Column`, `Row`, `inDisplayArea`) to RGB, including the border option. The sequencer registers its output.

## Test plan
- Reset held 3 cycles mid-frame, then released → RGB=0, `cmd_ready`=1, `pattern_idx`=0, state IDLE until the first `vsync_in` fall.
- Run 1+2×FRAMES_PER_PATTERN frames (param set to 2) → `pattern_idx` goes 0→1 after 2 AUTO frames, then to 2; `frame_tick` pulses once per frame.
- MANUAL command for pattern 2, issued mid-frame → `cmd_ready` is 0 until the boundary; the checkerboard starts on the next frame; pixel (32,0)=white, (0,0)=black (border disabled).
- `cmd_valid` asserted exactly on the boundary cycle → the command is not applied at that boundary and is applied at the next one.
- Pattern 1, pixel (213,10) and (214,10) → RGB (255,0,0) then (0,255,0), each 1 cycle after input; with `VGA_SEQ_BORDER_EN` defined, (0,10) is white.
- AUTO at pattern 3 wraps to 0; `inDisplayArea`=0 → RGB=0 regardless of pattern.
